alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 196 +++++++++++++++++++
 tb/tb_alu_issue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Single-issue front end for an external combinational ALU. It accepts one
// instruction at a time, reads the source operands from a small internal
// register file, drives registered opcode/operands to the ALU, captures the
// ALU result one cycle later and writes it back in the following cycle.
//
// Instruction word:
//   opcode[29:25]  dst[24:22]  src0[21:19]  src1[18:16]  imm[15:0]
//   (inst[31:30] are not used)
//
// Register file: 8 x 32
//   r0      reads 0
//   r1      reads the sign-extended imm of the instruction being accepted
//   r2..r7  read stored values
//   Writes to r0/r1 are dropped; writeback is still signalled.
//
// Opcode 31 is HALT: the block stops in HALT with no writeback until reset.
//
// Handshake: an instruction transfers on a rising clk edge where
// inst_valid & inst_ready are both high. inst_ready depends only on the
// current state, never on inst_valid. An offer while inst_ready is low is
// ignored and changes nothing.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   inst_valid instruction offered
//   inst_ready block can accept an instruction this cycle
//   inst       instruction word
//   opcode     registered opcode to ALU
//   alu0/alu1  registered operands to ALU
//   aluout     combinational ALU result
//   wb_valid   one-cycle writeback pulse
//   wb_dst     writeback destination register
//   wb_data    writeback value
//   halted     high while in HALT
//   state_dbg  current FSM state (IDLE=0, EXEC=1, WB=2, HALT=3)
//
// Configuration macro: ALU_ISSUE_FWD_EN
//   defined   : inst_ready is also high in WB and the value being written
//               back is forwarded to a same-cycle source read (2 cycles per
//               instruction back to back).
//   undefined : no acceptance in WB, no forwarding (3 cycles per instruction).
// -----------------------------------------------------------------------------
module alu_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_valid,
   output logic        inst_ready,
   input  logic [31:0] inst,
   output logic [4:0]  opcode,
   output logic [31:0] alu0,
   output logic [31:0] alu1,
   input  logic [31:0] aluout,
   output logic        wb_valid,
   output logic [2:0]  wb_dst,
   output logic [31:0] wb_data,
   output logic        halted,
   output logic [1:0]  state_dbg
);

   localparam logic [4:0] OP_HALT = 5'd31;

`ifdef ALU_ISSUE_FWD_EN
   localparam logic READY_IN_WB = 1'b1;
`else
   localparam logic READY_IN_WB = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      HALT = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        xfer;

   // decoded fields of the offered instruction
   logic [4:0]  f_op;
   logic [2:0]  f_dst;
   logic [2:0]  f_src0;
   logic [2:0]  f_src1;
   logic [31:0] imm_sext;
   logic        unused_inst;

   // entries 0 and 1 are never written after reset; reads of r0/r1 are
   // substituted in read_src
   logic [31:0] regs [8];

   logic [2:0]  exec_dst;   // dst of the instruction currently in EXEC
   logic [2:0]  res_dst;    // captured writeback destination
   logic [31:0] res_data;   // captured writeback value

   logic [31:0] file0;
   logic [31:0] file1;
   logic [31:0] src0_val;
   logic [31:0] src1_val;

   assign f_op        = inst[29:25];
   assign f_dst       = inst[24:22];
   assign f_src0      = inst[21:19];
   assign f_src1      = inst[18:16];
   assign imm_sext    = {{16{inst[15]}}, inst[15:0]};
   assign unused_inst = ^inst[31:30];

   function automatic logic [31:0] read_src(input logic [2:0]  idx,
                                            input logic [31:0] imm_v,
                                            input logic [31:0] file_v);
      case (idx)
         3'd0:    read_src = '0;
         3'd1:    read_src = imm_v;
         default: read_src = file_v;
      endcase
   endfunction

`ifdef ALU_ISSUE_FWD_EN
   // In WB the register file is written only at the end of the cycle, so an
   // instruction accepted in the same cycle must see the value in flight.
   // A match on r0/r1 is harmless: read_src never uses file_v for those.
   logic in_wb;
   assign in_wb = (state == WB);
   assign file0 = (in_wb && (f_src0 == res_dst)) ? res_data : regs[f_src0];
   assign file1 = (in_wb && (f_src1 == res_dst)) ? res_data : regs[f_src1];
`else
   assign file0 = regs[f_src0];
   assign file1 = regs[f_src1];
`endif

   assign src0_val = read_src(f_src0, imm_sext, file0);
   assign src1_val = read_src(f_src1, imm_sext, file1);

   // acceptance depends on state only
   always_comb begin
      inst_ready = 1'b0;
      case (state)
         IDLE:    inst_ready = 1'b1;
         WB:      inst_ready = READY_IN_WB;
         default: inst_ready = 1'b0;
      endcase
   end

   assign xfer = inst_valid & inst_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (xfer) state_nxt = EXEC;
         EXEC: state_nxt = (opcode == OP_HALT) ? HALT : WB;
         WB:   state_nxt = xfer ? EXEC : IDLE;
         HALT: state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         opcode   <= '0;
         alu0     <= '0;
         alu1     <= '0;
         exec_dst <= '0;
         res_dst  <= '0;
         res_data <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         // ALU inputs change only on a transfer and hold otherwise
         if (xfer) begin
            opcode   <= f_op;
            alu0     <= src0_val;
            alu1     <= src1_val;
            exec_dst <= f_dst;
         end
         // halt has no result to capture
         if ((state == EXEC) && (opcode != OP_HALT)) begin
            res_dst  <= exec_dst;
            res_data <= aluout;
         end
         if ((state == WB) && (res_dst >= 3'd2)) begin
            regs[res_dst] <= res_data;
         end
      end
   end

   assign wb_valid  = (state == WB);
   assign wb_dst    = res_dst;
   assign wb_data   = res_data;
   assign halted    = (state == HALT);
   assign state_dbg = state;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
//
// Self-checking bench for alu_issue. The bench supplies the ALU (0 ADD,
// 1 SUB, 2 AND, 3 OR, 4 XOR, others ADD) and keeps an architectural model
// of the register file: instructions execute in order, so every expected
// operand and writeback follows directly from the model state.
// -----------------------------------------------------------------------------
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [4:0]  opcode;
  logic [31:0] alu0;
  logic [31:0] alu1;
  logic [31:0] aluout;
  logic        wb_valid;
  logic [2:0]  wb_dst;
  logic [31:0] wb_data;
  logic        halted;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mregs [8];

  alu_issue dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .opcode     (opcode),
    .alu0       (alu0),
    .alu1       (alu1),
    .aluout     (aluout),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // clock / reset ------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // environment and model -----------------------------------------------------
  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    alu_ref = a + b;
      5'd1:    alu_ref = a - b;
      5'd2:    alu_ref = a & b;
      5'd3:    alu_ref = a | b;
      5'd4:    alu_ref = a ^ b;
      default: alu_ref = a + b;
    endcase
  endfunction

  always_comb aluout = alu_ref(opcode, alu0, alu1);

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s0,
                                     input logic [2:0] s1, input logic [15:0] imm);
    mk = {2'b00, op, d, s0, s1, imm};
  endfunction

  function automatic logic [31:0] model_src(input logic [2:0] idx, input logic [15:0] imm);
    if (idx == 3'd0)      model_src = 32'd0;
    else if (idx == 3'd1) model_src = {{16{imm[15]}}, imm};
    else                  model_src = mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 32'd0;
  endtask

  // driver: offer w until accepted; waits = idle offers before transfer, -1 on timeout
  task automatic drive_inst(input logic [31:0] w, output int waits);
    waits = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      inst = w;
      inst_valid = 1'b1;
      if (inst_ready) begin
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        waits = k;
        break;
      end
    end
    inst_valid = 1'b0;
  endtask

  // tests -----------------------------------------------------------------------
  task automatic test_reset();
    int waits;
    reset = 1'b1; inst_valid = 1'b0; inst = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", inst_ready); end
    n_checks++; if (opcode !== 5'd0) begin n_fail++; $display("FAIL rst_opcode: got %h expected 0", opcode); end
    n_checks++; if (alu0 !== 32'd0 || alu1 !== 32'd0) begin n_fail++; $display("FAIL rst_alu: got %h/%h expected 0/0", alu0, alu1); end
    n_checks++; if (wb_valid !== 1'b0 || wb_dst !== 3'd0 || wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_wb: got %b/%h/%h expected 0/0/0", wb_valid, wb_dst, wb_data); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b expected 0", halted); end
    @(posedge clk); #1 reset = 1'b0;
    // ADD r2,r1,r0 imm=0xFFFF, offered on the first edge with reset low
    drive_inst(mk(5'd0, 3'd2, 3'd1, 3'd0, 16'hFFFF), waits);
    n_checks++; if (waits !== 0) begin n_fail++; $display("FAIL first_xfer: got wait %0d expected 0", waits); end
    @(negedge clk);
    n_checks++; if (alu0 !== 32'hFFFFFFFF || alu1 !== 32'd0) begin n_fail++; $display("FAIL sext_alu: got %h/%h expected ffffffff/0", alu0, alu1); end
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL sext_early_wb: got %b expected 0", wb_valid); end
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd2 || wb_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sext_wb: got %b/%h/%h expected 1/2/ffffffff", wb_valid, wb_dst, wb_data); end
    mregs[2] = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL wb_pulse: got %b expected 0", wb_valid); end
  endtask

  task automatic test_reset_mid_exec();
    int waits;
    drive_inst(mk(5'd0, 3'd2, 3'd1, 3'd1, 16'd5), waits);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (wb_valid !== 1'b0 || opcode !== 5'd0 || alu0 !== 32'd0) begin n_fail++; $display("FAIL midrst_async: got %b/%h/%h expected 0/0/0", wb_valid, opcode, alu0); end
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b0 || inst_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_drop: got wb %b ready %b expected 0/1", wb_valid, inst_ready); end
    // r2 must read 0 after the dropped write
    drive_inst(mk(5'd0, 3'd6, 3'd2, 3'd2, 16'd0), waits);
    @(negedge clk);
    n_checks++; if (alu0 !== 32'd0 || alu1 !== 32'd0) begin n_fail++; $display("FAIL midrst_r2: got %h/%h expected 0/0", alu0, alu1); end
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd6 || wb_data !== 32'd0) begin n_fail++; $display("FAIL midrst_wb: got %b/%h/%h expected 1/6/0", wb_valid, wb_dst, wb_data); end
    mregs[6] = 32'd0;
  endtask

  task automatic test_r0_r1_discard();
    int waits;
    drive_inst(mk(5'd0, 3'd0, 3'd1, 3'd1, 16'd3), waits);
    @(negedge clk);
    n_checks++; if (alu0 !== 32'd3 || alu1 !== 32'd3) begin n_fail++; $display("FAIL r0w_alu: got %h/%h expected 3/3", alu0, alu1); end
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd0 || wb_data !== 32'd6) begin n_fail++; $display("FAIL r0w_wb: got %b/%h/%h expected 1/0/6", wb_valid, wb_dst, wb_data); end
    drive_inst(mk(5'd0, 3'd5, 3'd0, 3'd0, 16'h1111), waits);
    @(negedge clk);
    n_checks++; if (alu0 !== 32'd0 || alu1 !== 32'd0) begin n_fail++; $display("FAIL r0r_alu: got %h/%h expected 0/0", alu0, alu1); end
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd5 || wb_data !== 32'd0) begin n_fail++; $display("FAIL r0r_wb: got %b/%h/%h expected 1/5/0", wb_valid, wb_dst, wb_data); end
    mregs[5] = 32'd0;
  endtask

  task automatic test_random();
    int waits;
    logic [4:0]  op;
    logic [2:0]  d, s0, s1;
    logic [15:0] imm;
    logic [31:0] e_a0, e_a1, e_res;
    for (int it = 0; it < 40; it++) begin
      op  = 5'($urandom_range(0, 4));
      d   = 3'($urandom_range(0, 7));
      s0  = 3'($urandom_range(0, 7));
      s1  = 3'($urandom_range(0, 7));
      imm = 16'($urandom_range(0, 65535));
      e_a0  = model_src(s0, imm);
      e_a1  = model_src(s1, imm);
      e_res = alu_ref(op, e_a0, e_a1);
      drive_inst(mk(op, d, s0, s1, imm), waits);
      n_checks++; if (waits < 0) begin n_fail++; $display("FAIL rnd_accept: got timeout expected transfer"); end
      @(negedge clk);
      n_checks++; if (opcode !== op || alu0 !== e_a0 || alu1 !== e_a1) begin n_fail++; $display("FAIL rnd_alu_in: got %h/%h/%h expected %h/%h/%h", opcode, alu0, alu1, op, e_a0, e_a1); end
      @(negedge clk);
      n_checks++; if (wb_valid !== 1'b1 || wb_dst !== d || wb_data !== e_res) begin n_fail++; $display("FAIL rnd_wb: got %b/%h/%h expected 1/%h/%h", wb_valid, wb_dst, wb_data, d, e_res); end
      if (d >= 3'd2) mregs[d] = e_res;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int exp_acc;
    logic rdy;
`ifdef ALU_ISSUE_FWD_EN
    exp_acc = 2;
`else
    exp_acc = 3;
`endif
    @(negedge clk);
    inst = mk(5'd0, 3'd3, 3'd1, 3'd0, 16'd7);
    inst_valid = 1'b1;
    @(posedge clk);
    #1 inst = mk(5'd0, 3'd4, 3'd3, 3'd3, 16'h8421);
    acc = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd3 || wb_data !== 32'd7) begin n_fail++; $display("FAIL b2b_wb1: got %b/%h/%h expected 1/3/7", wb_valid, wb_dst, wb_data); end
      end
      rdy = inst_ready;
      @(posedge clk);
      if (rdy) begin acc = k; break; end
    end
    #1 inst_valid = 1'b0;
    mregs[3] = 32'd7;
    n_checks++; if (acc != exp_acc) begin n_fail++; $display("FAIL b2b_accept_edge: got %0d expected %0d", acc, exp_acc); end
    @(negedge clk);
    n_checks++; if (alu0 !== 32'd7 || alu1 !== 32'd7) begin n_fail++; $display("FAIL b2b_fwd: got %h/%h expected 7/7", alu0, alu1); end
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd4 || wb_data !== 32'd14) begin n_fail++; $display("FAIL b2b_wb2: got %b/%h/%h expected 1/4/e", wb_valid, wb_dst, wb_data); end
    mregs[4] = 32'd14;
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail: got %b expected 0", wb_valid); end
  endtask

  task automatic test_hold();
    logic [4:0]  op;
    logic [15:0] imm;
    logic [31:0] e_a0, e_a1, e_res;
    int extra;
    op  = 5'($urandom_range(0, 4));
    imm = 16'($urandom_range(0, 65535));
    e_a0  = model_src(3'd2, imm);
    e_a1  = model_src(3'd1, imm);
    e_res = alu_ref(op, e_a0, e_a1);
    @(negedge clk);
    inst = mk(op, 3'd7, 3'd2, 3'd1, imm);
    inst_valid = 1'b1;
    n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready: got %b expected 1", inst_ready); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL hold_exec_ready: got %b expected 0", inst_ready); end
    n_checks++; if (alu0 !== e_a0 || alu1 !== e_a1) begin n_fail++; $display("FAIL hold_alu: got %h/%h expected %h/%h", alu0, alu1, e_a0, e_a1); end
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_dst !== 3'd7 || wb_data !== e_res) begin n_fail++; $display("FAIL hold_wb: got %b/%h/%h expected 1/7/%h", wb_valid, wb_dst, wb_data, e_res); end
    mregs[7] = e_res;
    extra = 0;
    repeat (4) begin @(negedge clk); if (wb_valid) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL hold_once: got %0d extra writebacks expected 0", extra); end
  endtask

  task automatic test_halt();
    int waits;
    int bad;
    drive_inst(mk(5'd31, 3'd2, 3'd1, 3'd1, 16'h0042), waits);
    @(negedge clk);
    n_checks++; if (inst_ready !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_exec: got ready %b halted %b expected 0/0", inst_ready, halted); end
    @(negedge clk);
    n_checks++; if (halted !== 1'b1 || inst_ready !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got %b/%b/%b expected 1/0/0", halted, inst_ready, wb_valid); end
    inst = mk(5'd0, 3'd3, 3'd1, 3'd0, 16'd9);
    inst_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (halted !== 1'b1 || wb_valid !== 1'b0 || inst_ready !== 1'b0 || opcode !== 5'd31) bad++;
    end
    inst_valid = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad cycles expected 0", bad); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (halted !== 1'b0 || inst_ready !== 1'b1) begin n_fail++; $display("FAIL halt_reset: got halted %b ready %b expected 0/1", halted, inst_ready); end
  endtask

  // sequence and report ---------------------------------------------------------
  initial begin
    test_reset();
    test_reset_mid_exec();
    test_r0_r1_discard();
    test_random();
    test_back_to_back();
    test_hold();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
